// File: rtl/fetch_pkg.sv
// Shared types and constants for the byte-wide instruction fetch path.
// Used by the fetch unit, its wait timer, the control unit and the IR hookup.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FETCH_LO = 2'd1,
        S_FETCH_HI = 2'd2,
        S_DONE     = 2'd3
    } fetch_state_t;

    localparam logic LH_LOW  = 1'b0;
    localparam logic LH_HIGH = 1'b1;

    // Bits needed to hold a count up to and including t.
    function automatic int cnt_width(input int t);
        return (t < 1) ? 1 : $clog2(t + 1);
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Per-byte wait counter for the fetch handshake.
// Flags expiry when the last allowed wait cycle is reached.
module fetch_wait_timer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = cnt_width(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] wcnt;

    // Count idle request cycles; clear wins over increment.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wcnt <= '0;
        end else if (clear) begin
            wcnt <= '0;
        end else if (inc) begin
            wcnt <= wcnt + W'(1);
        end
    end

    assign expired = (wcnt == LAST);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetches one 16-bit instruction as two byte reads and feeds the IR.
// Owns the PC; reports completion or a per-byte timeout fault.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCIn,
    input  logic [7:0]        MemData,
    input  logic              MemValid,
    output logic              MemRead,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        IRByte,
    output logic              IRWrite,
    output logic              IRLH,
    output logic [ADDR_W-1:0] PCOut,
    output logic              Busy,
    output logic              FetchDone,
    output logic              Fault
);

    fetch_state_t      state;
    fetch_state_t      state_nx;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_nx;
    logic [ADDR_W-1:0] start_pc;
    logic [ADDR_W-1:0] start_pc_nx;
    logic              wt_clear;
    logic              wt_inc;
    logic              wt_expired;

    fetch_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .Clock  (Clock),
        .Reset  (Reset),
        .clear  (wt_clear),
        .inc    (wt_inc),
        .expired(wt_expired)
    );

    // State, PC and the restart point for an aborted fetch.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            start_pc <= '0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            start_pc <= start_pc_nx;
        end
    end

    // Next state, PC updates and handshake outputs.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        start_pc_nx = start_pc;
        wt_clear    = 1'b0;
        wt_inc      = 1'b0;
        MemRead     = 1'b0;
        MemAddr     = '0;
        IRByte      = '0;
        IRWrite     = 1'b0;
        IRLH        = LH_LOW;
        FetchDone   = 1'b0;
        Fault       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (PCLoad) begin
                    pc_nx = PCIn;
                end
                if (Start) begin
                    start_pc_nx = PCLoad ? PCIn : pc;
                    wt_clear    = 1'b1;
                    state_nx    = S_FETCH_LO;
                end
            end
            S_FETCH_LO, S_FETCH_HI: begin
                MemRead = 1'b1;
                MemAddr = pc;
                IRLH    = (state == S_FETCH_HI) ? LH_HIGH : LH_LOW;
                IRWrite = MemValid;
                IRByte  = MemData;
                if (MemValid) begin
                    pc_nx    = pc + ADDR_W'(1);
                    wt_clear = 1'b1;
                    state_nx = (state == S_FETCH_LO) ? S_FETCH_HI : S_DONE;
                end else if (wt_expired) begin
                    Fault    = 1'b1;
                    pc_nx    = start_pc;
                    wt_clear = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    wt_inc = 1'b1;
                end
            end
            S_DONE: begin
                FetchDone = 1'b1;
                state_nx  = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign PCOut = pc;
    assign Busy  = (state != S_IDLE);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the byte-wide instruction register load path.
- Owns the program counter and fetches one 16-bit instruction as two 8-bit reads from byte-wide memory, using a valid handshake.
- Drives the instruction register's byte input, write enable and low/high select: first byte to low half, second byte to high half.
- Signals completion, or a timeout fault, to the control unit.

Parameters:
- ADDR_W, 8, width of PC and memory address.
- TIMEOUT, 15, max cycles waited for MemValid per byte before fault; must be ≥1.

Ports:
- Clock  input  1  single system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request one instruction fetch; sampled only in IDLE.
- PCLoad  input  1  load PC from PCIn; honoured only in IDLE.
- PCIn  input  ADDR_W  new PC value.
- MemData  input  8  read data from memory.
- MemValid  input  1  MemData valid this cycle for the outstanding read.
- MemRead  output  1  read request, held until MemValid.
- MemAddr  output  ADDR_W  read address.
- IRByte  output  8  byte to instruction register (passthrough of MemData).
- IRWrite  output  1  instruction register write enable.
- IRLH  output  1  0 = write low byte, 1 = write high byte.
- PCOut  output  ADDR_W  current PC.
- Busy  output  1  high in any state other than IDLE.
- FetchDone  output  1  one-cycle pulse, instruction complete.
- Fault  output  1  one-cycle pulse, timeout abort.

Behaviour:
- States are IDLE, FETCH_LO, FETCH_HI, DONE, held in a registered state.
- Registered values are PC, StartPC and the wait counter WCnt, which is wide enough to hold TIMEOUT.
- Reset values:
  - state = IDLE; PC = 0; StartPC = 0; WCnt = 0.
  - All outputs are 0: MemRead, IRWrite, IRLH, FetchDone, Fault, Busy, MemAddr, IRByte, PCOut.
- IDLE:
  - PCLoad=1 sets PC <= PCIn.
  - Start=1 sets StartPC <= (PCLoad ? PCIn : PC), WCnt <= 0, and moves to FETCH_LO.
  - When both are asserted, the fetch begins at PCIn.
- FETCH_LO:
  - MemRead=1, MemAddr=PC, IRLH=0.
  - IRWrite = MemValid and IRByte = MemData, both combinational, so the IR captures the byte on the same edge the handshake completes.
  - On MemValid: PC <= PC+1, WCnt <= 0, move to FETCH_HI.
  - Else WCnt <= WCnt+1.
- FETCH_HI: identical to FETCH_LO except IRLH=1. On MemValid: PC <= PC+1, move to DONE.
- DONE: FetchDone=1 for exactly one cycle, then IDLE. Net PC advance is 2 per instruction.
- Timeout:
  - In FETCH_LO or FETCH_HI, if WCnt == TIMEOUT-1 and MemValid=0, the fetch aborts.
  - Abort actions: Fault=1 (combinational, that cycle), PC <= StartPC, state <= IDLE.
  - A partially written IR is left as is; the control unit must refetch.
  - MemValid arriving on that same cycle wins: normal progress, no fault.
- Wrap-around: PC increments modulo 2^ADDR_W, so a fetch starting at 2^ADDR_W-1 reads the high byte at address 0.
- Ignored inputs:
  - MemValid is ignored in IDLE and DONE.
  - Start and PCLoad are ignored outside IDLE and are not queued.
- Reset mid-fetch: the fetch is abandoned on the next edge and all values return to reset, with no FetchDone or Fault pulse.
- Latency with zero-wait memory (MemValid high on the first request cycle):
  - Start edge → FETCH_LO (1) → FETCH_HI (2) → DONE (3).
  - FetchDone is high in cycle 3 after Start.
  - Each wait cycle adds 1.
- Outputs are derived from state and inputs only. No combinational path exists from Start to MemRead; MemRead rises the cycle after Start.
- PCOut = PC at all times.
- Busy = (state != IDLE).

Decomposition:
- Shared package fetch_pkg:
  - State encoding constants S_IDLE=2'd0, S_FETCH_LO=2'd1, S_FETCH_HI=2'd2, S_DONE=2'd3.
  - Constants LH_LOW=1'b0, LH_HIGH=1'b1, for reuse by the control unit and the IR hookup.
- One natural sub-module, fetch_wait_timer: the WCnt counter with clear, increment and expired outputs, parameterised by TIMEOUT.
- PC register and FSM stay in the top block.

Test Plan:
- Zero-wait fetch:
  - Stimulus: PC=0x10, memory holds 0x10→0x34 and 0x11→0x12, MemValid echoes MemRead; pulse Start.
  - Response: IRWrite with IRLH=0/IRByte=0x34, then IRLH=1/IRByte=0x12; attached IR reads 0x1234; FetchDone in cycle 3; PCOut=0x12.
- Wait states: MemValid delayed 3 cycles per byte → MemRead and MemAddr held stable while waiting; FetchDone at cycle 9; PC=start+2.
- Timeout:
  - Stimulus: TIMEOUT=4, MemValid held 0 after Start at PC=0x20.
  - Response: Fault pulse on the 4th FETCH_LO cycle; state IDLE; PCOut=0x20; no FetchDone.
- Wrap and load:
  - Stimulus: PCLoad=1 and Start=1 together with PCIn=0xFF.
  - Response: reads at 0xFF then 0x00; PCOut=0x01 after FetchDone.
- Ignored controls: during FETCH_HI assert PCLoad with PCIn=0x55 and Start → no effect; PC=start+2 at completion; no second fetch.
- Reset mid-fetch: assert Reset in FETCH_HI → next cycle all outputs 0, PCOut=0, no FetchDone or Fault; a fresh Start fetches from 0x00.
